id_ex_stage: RTL and testbench

ID/EX pipeline stage of the five-stage RV32 core, directly downstream of the decode control unit and register file. It registers the decoded control bundle, operands, immediate and register addresses for the EX stage, and detects load-use hazards, which it resolves by stalling ID/IF and inserting a bubble. It also applies branch flushes and global memory-wait holds, so EX always sees either a valid instruction or a clean no-op.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/hazard_detect.sv | 27 ++
 rtl/id_ex_stage.sv | 125 ++++++++++++
 tb/tb_id_ex_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared RV32 core types: control bundle, ALUOp codes, opcodes.
// Used by decode, id_ex_stage and hazard_detect.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  localparam logic [1:0] ALUOP_LDST = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_R    = 2'b10;

  localparam logic [4:0] X0_ADDR = 5'd0;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Non-instructions carry no control; MemtoReg only matters with RegWrite.
  function automatic ctrl_t ctrl_clean(
    input logic  valid,
    input ctrl_t c
  );
    ctrl_t r;
    r = valid ? c : CTRL_BUBBLE;
    r.mem_to_reg = r.mem_to_reg & r.reg_write;
    return r;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between EX (load) and ID.
// Compares both rs fields regardless of instruction format.
module hazard_detect
  import cpu_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  output logic              haz
);

  logic rd_nz;
  logic hit;

  assign rd_nz = (ex_rd != '0);
  assign hit   = (ex_rd == id_rs1)
               | (ex_rd == id_rs2);

  assign haz = ex_valid & ex_mem_read
             & rd_nz & id_valid & hit;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush and hold.
// ID_EX_BUBBLE_CNT_EN adds a saturating bubble counter output.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              ALUSrc_i,
  input  logic              Branch_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [9:0]        funct_i,
  output logic [1:0]        ALUOp_o,
  output logic              ALUSrc_o,
  output logic              Branch_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [REG_AW-1:0] rs1_addr_o,
  output logic [REG_AW-1:0] rs2_addr_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic [9:0]        funct_o,
`ifdef ID_EX_BUBBLE_CNT_EN
  output logic [31:0]       bubble_cnt_o,
`endif
  output logic              valid_o,
  output logic              stall_o
);

  ctrl_t ctrl_in;
  ctrl_t ctrl_q;
  logic  haz;
  logic  bubble;

  assign ctrl_in = ctrl_clean(valid_i, {
    ALUOp_i, ALUSrc_i, Branch_i,
    MemRead_i, MemWrite_i,
    RegWrite_i, MemtoReg_i});

  hazard_detect #(
    .REG_AW(REG_AW)
  ) u_haz (
    .ex_valid   (valid_o),
    .ex_mem_read(ctrl_q.mem_read),
    .ex_rd      (rd_addr_o),
    .id_valid   (valid_i),
    .id_rs1     (rs1_addr_i),
    .id_rs2     (rs2_addr_i),
    .haz        (haz)
  );

  assign stall_o = haz & ~flush_i & ~hold_i;
  assign bubble  = ~hold_i & (flush_i | haz);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o    <= 1'b0;
      ctrl_q     <= CTRL_BUBBLE;
      rd_addr_o  <= '0;
      pc_o       <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
      rs1_addr_o <= '0;
      rs2_addr_o <= '0;
      funct_o    <= '0;
    end else if (!hold_i) begin
      if (flush_i || haz) begin
        valid_o   <= 1'b0;
        ctrl_q    <= CTRL_BUBBLE;
        rd_addr_o <= '0;
      end else begin
        valid_o    <= valid_i;
        ctrl_q     <= ctrl_in;
        rd_addr_o  <= rd_addr_i;
        pc_o       <= pc_i;
        rs1_data_o <= rs1_data_i;
        rs2_data_o <= rs2_data_i;
        imm_o      <= imm_i;
        rs1_addr_o <= rs1_addr_i;
        rs2_addr_o <= rs2_addr_i;
        funct_o    <= funct_i;
      end
    end
  end

  assign ALUOp_o    = ctrl_q.alu_op;
  assign ALUSrc_o   = ctrl_q.alu_src;
  assign Branch_o   = ctrl_q.branch;
  assign MemRead_o  = ctrl_q.mem_read;
  assign MemWrite_o = ctrl_q.mem_write;
  assign RegWrite_o = ctrl_q.reg_write;
  assign MemtoReg_o = ctrl_q.mem_to_reg;

`ifdef ID_EX_BUBBLE_CNT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      bubble_cnt_o <= '0;
    else if (bubble && bubble_cnt_o != '1)
      bubble_cnt_o <= bubble_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX bundles are queued
// at drive time and compared one edge later.
module tb_id_ex_stage;
  import cpu_pkg::*;

  typedef struct packed {
    logic        v;
    ctrl_t       c;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  rd;
    logic [9:0]  f;
  } exp_t;

  typedef enum logic [1:0] {CAP, BUB, HLD} kind_e;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic        in_v = 1'b0;
  ctrl_t       in_c = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_d1 = '0;
  logic [31:0] in_d2 = '0;
  logic [31:0] in_imm = '0;
  logic [4:0]  in_a1 = '0;
  logic [4:0]  in_a2 = '0;
  logic [4:0]  in_rd = '0;
  logic [9:0]  in_f = '0;

  logic [1:0]  alu_op;
  logic        alu_src, branch, mem_read;
  logic        mem_write, reg_write, mem_to_reg;
  logic [31:0] pc_q, d1_q, d2_q, imm_q;
  logic [4:0]  a1_q, a2_q, rd_q;
  logic [9:0]  f_q;
  logic        valid_q, stall;

  exp_t q[$];
  exp_t last = '0;
  int   n_chk = 0;
  int   n_fail = 0;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
  int          exp_cnt = 0;
`endif

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .hold_i     (hold),
    .flush_i    (flush),
    .valid_i    (in_v),
    .ALUOp_i    (in_c.alu_op),
    .ALUSrc_i   (in_c.alu_src),
    .Branch_i   (in_c.branch),
    .MemRead_i  (in_c.mem_read),
    .MemWrite_i (in_c.mem_write),
    .RegWrite_i (in_c.reg_write),
    .MemtoReg_i (in_c.mem_to_reg),
    .pc_i       (in_pc),
    .rs1_data_i (in_d1),
    .rs2_data_i (in_d2),
    .imm_i      (in_imm),
    .rs1_addr_i (in_a1),
    .rs2_addr_i (in_a2),
    .rd_addr_i  (in_rd),
    .funct_i    (in_f),
    .ALUOp_o    (alu_op),
    .ALUSrc_o   (alu_src),
    .Branch_o   (branch),
    .MemRead_o  (mem_read),
    .MemWrite_o (mem_write),
    .RegWrite_o (reg_write),
    .MemtoReg_o (mem_to_reg),
    .pc_o       (pc_q),
    .rs1_data_o (d1_q),
    .rs2_data_o (d2_q),
    .imm_o      (imm_q),
    .rs1_addr_o (a1_q),
    .rs2_addr_o (a2_q),
    .rd_addr_o  (rd_q),
    .funct_o    (f_q),
`ifdef ID_EX_BUBBLE_CNT_EN
    .bubble_cnt_o(bubble_cnt),
`endif
    .valid_o    (valid_q),
    .stall_o    (stall)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  function automatic ctrl_t mk(
    input logic [1:0] op,
    input logic src, br, mr, mw, rw, m2r
  );
    return ctrl_t'({op, src, br, mr, mw, rw, m2r});
  endfunction

  task automatic set_id(
    input logic        v,
    input ctrl_t       c,
    input logic [4:0]  rd,
    input logic [4:0]  a1,
    input logic [4:0]  a2,
    input logic [31:0] pc,
    input logic [31:0] d1
  );
    in_v   = v;
    in_c   = c;
    in_rd  = rd;
    in_a1  = a1;
    in_a2  = a2;
    in_pc  = pc;
    in_d1  = d1;
    in_d2  = d1 ^ 32'hA5A5_0000;
    in_imm = pc + 32'd4;
    in_f   = {5'd0, rd};
  endtask

  function automatic exp_t observed();
    exp_t o;
    o.v   = valid_q;
    o.c   = {alu_op, alu_src, branch, mem_read,
             mem_write, reg_write, mem_to_reg};
    o.pc  = pc_q;
    o.d1  = d1_q;
    o.d2  = d2_q;
    o.imm = imm_q;
    o.a1  = a1_q;
    o.a2  = a2_q;
    o.rd  = rd_q;
    o.f   = f_q;
    return o;
  endfunction

  task automatic cmp_all(input string tag, input exp_t e);
    exp_t o;
    o = observed();
    check({tag, ":valid"}, 64'(o.v), 64'(e.v));
    check({tag, ":ctrl"}, 64'(o.c), 64'(e.c));
    check({tag, ":rd"}, 64'(o.rd), 64'(e.rd));
    check({tag, ":pc"}, 64'(o.pc), 64'(e.pc));
    check({tag, ":d1"}, 64'(o.d1), 64'(e.d1));
    check({tag, ":d2"}, 64'(o.d2), 64'(e.d2));
    check({tag, ":imm"}, 64'(o.imm), 64'(e.imm));
    check({tag, ":a1"}, 64'(o.a1), 64'(e.a1));
    check({tag, ":a2"}, 64'(o.a2), 64'(e.a2));
    check({tag, ":funct"}, 64'(o.f), 64'(e.f));
  endtask

  task automatic step(
    input kind_e k,
    input logic  exp_stall,
    input string tag
  );
    exp_t e;
    #1;
    check({tag, ":stall"}, 64'(stall), 64'(exp_stall));
    e = last;
    case (k)
      CAP: begin
        e.v   = in_v;
        e.c   = in_v ? in_c : '0;
        e.c.mem_to_reg = e.c.mem_to_reg & e.c.reg_write;
        e.pc  = in_pc;
        e.d1  = in_d1;
        e.d2  = in_d2;
        e.imm = in_imm;
        e.a1  = in_a1;
        e.a2  = in_a2;
        e.rd  = in_rd;
        e.f   = in_f;
      end
      BUB: begin
        e.v  = 1'b0;
        e.c  = '0;
        e.rd = '0;
`ifdef ID_EX_BUBBLE_CNT_EN
        exp_cnt++;
`endif
      end
      default: ;
    endcase
    last = e;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0)
      check({tag, ":queue"}, 64'd0, 64'd1);
    else
      cmp_all(tag, q.pop_front());
`ifdef ID_EX_BUBBLE_CNT_EN
    check({tag, ":cnt"}, 64'(bubble_cnt), 64'(exp_cnt));
`endif
  endtask

  localparam ctrl_t C_R  = 8'b10_0000_10;
  localparam ctrl_t C_LW = 8'b00_1010_11;

  initial begin
    #12;
    cmp_all("reset", '0);
    check("reset:stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    set_id(1, C_R, 5, 1, 2, 32'h100, 32'h10);
    step(CAP, 0, "rtype");

    set_id(1, C_LW, 6, 2, 0, 32'h104, 32'h20);
    step(CAP, 0, "lw_x6");
    set_id(1, C_R, 7, 3, 6, 32'h108, 32'h30);
    step(BUB, 1, "luse_bub");
    step(CAP, 0, "luse_add");

    set_id(1, C_LW, 0, 4, 0, 32'h10C, 32'h40);
    step(CAP, 0, "ld_x0");
    set_id(1, C_R, 1, 0, 0, 32'h110, 32'h50);
    step(CAP, 0, "x0_nostall");

    set_id(1, C_LW, 8, 1, 0, 32'h114, 32'h60);
    step(CAP, 0, "lw_x8");
    set_id(1, C_R, 2, 8, 3, 32'h118, 32'h70);
    flush = 1'b1;
    step(BUB, 0, "flush_haz");
    flush = 1'b0;
    set_id(1, mk(2'b10, 0, 0, 0, 0, 1, 0),
           9, 1, 2, 32'h200, 32'h80);
    step(CAP, 0, "after_flush");

    set_id(1, C_LW, 10, 1, 0, 32'h204, 32'h90);
    step(CAP, 0, "lw_x10");
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, C_R, 5'(11 + i), 10, 4,
             32'h300 + 32'(i), 32'hB0 + 32'(i));
      step(HLD, 0, "hold");
    end
    hold = 1'b0;
    step(BUB, 1, "hold_rel_bub");
    step(CAP, 0, "hold_rel_cap");

    set_id(0, 8'hFF, 12, 3, 4, 32'h400, 32'hC0);
    step(CAP, 0, "inv_ctrl0");
    set_id(1, mk(2'b00, 1, 0, 0, 1, 0, 1),
           0, 5, 6, 32'h404, 32'hD0);
    step(CAP, 0, "m2r_mask");

    set_id(1, C_LW, 11, 2, 0, 32'h408, 32'hE0);
    step(CAP, 0, "lw_x11");
    set_id(1, C_R, 13, 11, 0, 32'h40C, 32'hF0);
    #1;
    check("pre_rst:stall", 64'(stall), 64'd1);
    rst_n = 1'b0;
    #1;
    cmp_all("rst_mid", '0);
    check("rst_mid:stall", 64'(stall), 64'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
    check("rst_mid:cnt", 64'(bubble_cnt), 64'd0);
    exp_cnt = 0;
`endif
    last = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    step(CAP, 0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
